// File: rtl/ws2812_frame_sched_if.sv
// ============================================================================
// Module      : ws2812_frame_sched_if
// Description : Byte-in / bit-out handshake bundle for the WS2812 frame
//               sequencer (SPI byte side and bit-encoder side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ws2812_frame_sched_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       enc_bit;
  logic       enc_valid;
  logic       enc_ready;
  logic       enc_idle;

  modport master (
    input  byte_data, byte_valid, enc_ready, enc_idle,
    output byte_ready, enc_bit, enc_valid
  );

  modport slave (
    output byte_data, byte_valid, enc_ready, enc_idle,
    input  byte_ready, enc_bit, enc_valid
  );
endinterface

`default_nettype wire

// File: rtl/ws2812_frame_sched.sv
// ============================================================================
// Module      : ws2812_frame_sched
// Description : WS2812 frame sequencer: pulls 3*NUM_LEDS bytes, shifts them
//               MSB-first to the bit encoder, then holds the latch period.
//               Optional stall watchdog enabled by defining WS_UNDERRUN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_frame_sched #(
  parameter int NUM_LEDS     = 8,
  parameter int LATCH_CYCLES = 2800,
  parameter int STALL_CYCLES = 1000
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_start,
  ws2812_frame_sched_if.master  bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_underrun
);

  localparam int IDX_W   = $clog2(3 * NUM_LEDS);
  localparam int LATCH_W = $clog2(LATCH_CYCLES);

  localparam logic [IDX_W-1:0]   c_IDX_LAST   = IDX_W'(3 * NUM_LEDS - 1);
  localparam logic [IDX_W-1:0]   c_IDX_ONE    = IDX_W'(1);
  localparam logic [LATCH_W-1:0] c_LATCH_LOAD = LATCH_W'(LATCH_CYCLES - 1);
  localparam logic [LATCH_W-1:0] c_LATCH_ONE  = LATCH_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_byte_idx;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shreg;
  logic [LATCH_W-1:0] r_latch_cnt;
  logic               r_done;

`ifdef WS_UNDERRUN_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] c_STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [STALL_W-1:0] c_STALL_ONE  = STALL_W'(1);

  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_underrun;
`else
  // Watchdog compiled out; keep its parameter referenced.
  logic w_unused_stall_cfg;
  assign w_unused_stall_cfg = (STALL_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_byte_idx  <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_latch_cnt <= '0;
      r_done      <= 1'b0;
`ifdef WS_UNDERRUN_EN
      r_stall_cnt <= '0;
      r_underrun  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LOAD;
            r_byte_idx <= '0;
`ifdef WS_UNDERRUN_EN
            r_stall_cnt <= '0;
            r_underrun  <= 1'b0;
`endif
          end
        end

        S_LOAD: begin
          if (bus.byte_valid) begin
            r_shreg   <= bus.byte_data;
            r_bit_cnt <= 3'd7;
            r_state   <= S_SHIFT;
`ifdef WS_UNDERRUN_EN
            r_stall_cnt <= '0;
`endif
          end
`ifdef WS_UNDERRUN_EN
          // The first byte of a frame may take arbitrarily long to arrive.
          else if (r_byte_idx != '0) begin
            if (r_stall_cnt == c_STALL_LAST) begin
              r_underrun  <= 1'b1;
              r_state     <= S_LATCH;
              r_latch_cnt <= c_LATCH_LOAD;
            end else begin
              r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
            end
          end
`endif
        end

        S_SHIFT: begin
          if (bus.enc_ready) begin
            r_shreg   <= {r_shreg[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 3'd1;
            if (r_bit_cnt == 3'd0) begin
              if (r_byte_idx == c_IDX_LAST) begin
                r_state     <= S_LATCH;
                r_latch_cnt <= c_LATCH_LOAD;
              end else begin
                r_byte_idx <= r_byte_idx + c_IDX_ONE;
                r_state    <= S_LOAD;
              end
            end
          end
        end

        S_LATCH: begin
          // The latch period only counts once the encoder has drained.
          if (!bus.enc_idle) begin
            r_latch_cnt <= c_LATCH_LOAD;
          end else if (r_latch_cnt == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_latch_cnt <= r_latch_cnt - c_LATCH_ONE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = (r_state == S_LOAD);
  assign bus.enc_valid  = (r_state == S_SHIFT);
  assign bus.enc_bit    = r_shreg[7];
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
`ifdef WS_UNDERRUN_EN
  assign o_underrun     = r_underrun;
`else
  assign o_underrun     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ws2812_frame_sched.sv
// ============================================================================
// Module      : tb_ws2812_frame_sched
// Description : Self-checking bench for ws2812_frame_sched with a frame-level
//               reference model (bit order, latch timing, watchdog timing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws2812_frame_sched;
  localparam int NUM_LEDS     = 2;
  localparam int LATCH_CYCLES = 16;
  localparam int STALL_CYCLES = 8;
  localparam int FRAME        = 3 * NUM_LEDS;
  localparam int NBITS        = 8 * FRAME;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, underrun;

  ws2812_frame_sched_if bus ();

  ws2812_frame_sched #(
    .NUM_LEDS     (NUM_LEDS),
    .LATCH_CYCLES (LATCH_CYCLES),
    .STALL_CYCLES (STALL_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .bus        (bus.master),
    .o_busy     (busy),
    .o_done     (done),
    .o_underrun (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0]       frame_q [FRAME];
  logic [NBITS-1:0] obs_vec;
  int obs_nbits, obs_last_hs, obs_done_cyc, obs_done_pulses, obs_unstable;
  int obs_overlap, obs_underrun_cyc, obs_bytes, obs_busy_gap;
  bit obs_busy_at_done, obs_chain_ok, obs_load_next, obs_underrun_at_start;

  // Expected serial stream: bytes in supplied order, each MSB first.
  function automatic logic [NBITS-1:0] model_bits();
    logic [NBITS-1:0] v = '0;
    for (int i = 0; i < FRAME; i++) v = {v[NBITS-9:0], frame_q[i]};
    return v;
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < FRAME; i++) frame_q[i] = 8'($urandom);
  endtask

  // Drives one frame and records what the DUT did; tests judge the record.
  task automatic run_frame(input bit issue_start, input int ready_pct, input int idle_low,
                           input int hold_byte, input int hold_cycles,
                           input bit poke_start, input bit chain);
    int hold_rem = hold_cycles;
    int idle_rem = 0;
    int after_done = -1;
    int budget = 0;
    bit prev_stall = 1'b0;
    logic prev_bit = 1'b0;
    obs_vec = '0; obs_nbits = 0; obs_last_hs = -1; obs_done_cyc = -1;
    obs_done_pulses = 0; obs_unstable = 0; obs_overlap = 0; obs_underrun_cyc = -1;
    obs_bytes = 0; obs_busy_gap = 0; obs_busy_at_done = 1'b1; obs_chain_ok = 1'b0;
    bus.enc_idle = 1'b1;
    if (issue_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    obs_load_next = bus.byte_ready;
    obs_underrun_at_start = underrun;
    while (after_done != 0 && budget < 4000) begin
      budget++;
      if (after_done > 0) after_done--;
      if (prev_stall && (bus.enc_valid !== 1'b1 || bus.enc_bit !== prev_bit)) obs_unstable++;
      if (bus.byte_ready === 1'b1 && bus.enc_valid === 1'b1) obs_overlap++;
      if (underrun === 1'b1 && obs_underrun_cyc < 0) obs_underrun_cyc = cyc;
      if (obs_done_cyc < 0 && done !== 1'b1 && busy !== 1'b1) obs_busy_gap++;
      if (chain && obs_done_cyc >= 0 && cyc == obs_done_cyc + 1)
        obs_chain_ok = (bus.byte_ready === 1'b1) && (busy === 1'b1);
      if (done === 1'b1) begin
        obs_done_pulses++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = cyc;
          obs_busy_at_done = busy;
          after_done = 4;
        end
      end
      bus.byte_data = frame_q[(obs_bytes < FRAME) ? obs_bytes : 0];
      if (obs_bytes == hold_byte && hold_rem > 0 && bus.byte_ready === 1'b1) begin
        bus.byte_valid = 1'b0;
        hold_rem--;
      end else begin
        bus.byte_valid = (obs_bytes < FRAME);
      end
      bus.enc_ready = ($urandom_range(0, 99) < ready_pct);
      bus.enc_idle  = (idle_rem == 0);
      if (idle_rem > 0) idle_rem--;
      start = 1'b0;
      if (chain && done === 1'b1 && obs_done_pulses == 1) start = 1'b1;
      else if (poke_start && busy === 1'b1 && $urandom_range(0, 3) == 0) start = 1'b1;
      if (bus.byte_valid && bus.byte_ready === 1'b1) obs_bytes++;
      if (bus.enc_valid === 1'b1 && bus.enc_ready) begin
        obs_vec = {obs_vec[NBITS-2:0], bus.enc_bit};
        obs_nbits++;
        obs_last_hs = cyc;
        if (obs_nbits == NBITS) idle_rem = idle_low;
      end
      prev_stall = (bus.enc_valid === 1'b1) && !bus.enc_ready;
      prev_bit   = bus.enc_bit;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.enc_ready  = 1'b0;
    bus.enc_idle   = 1'b1;
  endtask

  task automatic test_reset();
    int waited = 0;
    int bad = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || underrun !== 1'b0) begin errors++; $display("FAIL reset_done_underrun: got %b%b expected 00", done, underrun); end
    checks++; if (bus.byte_ready !== 1'b0 || bus.enc_valid !== 1'b0) begin errors++; $display("FAIL reset_handshake: got ready=%b valid=%b expected 0 0", bus.byte_ready, bus.enc_valid); end
    rand_frame();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    bus.byte_data = frame_q[0]; bus.byte_valid = 1'b1; bus.enc_ready = 1'b0;
    while (bus.enc_valid !== 1'b1 && waited < 10) begin @(posedge clk); #1; waited++; end
    checks++; if (bus.enc_valid !== 1'b1) begin errors++; $display("FAIL reset_reach_shift: got enc_valid=%b expected 1", bus.enc_valid); end
    rst_n = 1'b0; bus.byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if ({busy, done, underrun, bus.byte_ready, bus.enc_valid, bus.enc_bit} !== 6'b0) begin
      errors++; $display("FAIL reset_midframe: got %b expected 000000",
                         {busy, done, underrun, bus.byte_ready, bus.enc_valid, bus.enc_bit}); end
    for (int i = 0; i < 3 * LATCH_CYCLES; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_no_done: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_full_frame();
    logic [7:0] pat [FRAME] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    for (int i = 0; i < FRAME; i++) frame_q[i] = pat[i];
    run_frame(1'b1, 100, 0, -1, 0, 1'b0, 1'b0);
    checks++; if (obs_load_next !== 1'b1) begin errors++; $display("FAIL full_load_next: got %b expected 1", obs_load_next); end
    checks++; if (obs_nbits != NBITS) begin errors++; $display("FAIL full_nbits: got %0d expected %0d", obs_nbits, NBITS); end
    checks++; if (obs_vec !== model_bits()) begin errors++; $display("FAIL full_bits: got %h expected %h", obs_vec, model_bits()); end
    checks++; if (obs_done_cyc != obs_last_hs + LATCH_CYCLES + 1) begin errors++;
      $display("FAIL full_done_time: got %0d expected %0d", obs_done_cyc - obs_last_hs, LATCH_CYCLES + 1); end
    checks++; if (obs_done_pulses != 1) begin errors++; $display("FAIL full_done_pulses: got %0d expected 1", obs_done_pulses); end
    checks++; if (obs_busy_at_done !== 1'b0) begin errors++; $display("FAIL full_busy_at_done: got %b expected 0", obs_busy_at_done); end
    checks++; if (obs_underrun_cyc >= 0 || obs_busy_gap != 0) begin errors++;
      $display("FAIL full_clean: got underrun_cyc=%0d busy_gap=%0d expected -1 0", obs_underrun_cyc, obs_busy_gap); end
  endtask

  task automatic test_backpressure();
    rand_frame();
    run_frame(1'b1, 30, 0, -1, 0, 1'b0, 1'b0);
    checks++; if (obs_vec !== model_bits() || obs_nbits != NBITS) begin errors++;
      $display("FAIL bp_bits: got %h (%0d bits) expected %h", obs_vec, obs_nbits, model_bits()); end
    checks++; if (obs_unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", obs_unstable); end
    checks++; if (obs_overlap != 0) begin errors++; $display("FAIL bp_overlap: got %0d expected 0", obs_overlap); end
    checks++; if (obs_done_cyc != obs_last_hs + LATCH_CYCLES + 1) begin errors++;
      $display("FAIL bp_done_time: got %0d expected %0d", obs_done_cyc - obs_last_hs, LATCH_CYCLES + 1); end
  endtask

  task automatic test_latch_hold();
    rand_frame();
    run_frame(1'b1, 100, 10, -1, 0, 1'b0, 1'b0);
    checks++; if (obs_vec !== model_bits()) begin errors++; $display("FAIL hold_bits: got %h expected %h", obs_vec, model_bits()); end
    checks++; if (obs_done_cyc != obs_last_hs + LATCH_CYCLES + 1 + 10) begin errors++;
      $display("FAIL hold_done_time: got %0d expected %0d", obs_done_cyc - obs_last_hs, LATCH_CYCLES + 11); end
  endtask

  task automatic test_first_byte_wait();
    rand_frame();
    run_frame(1'b1, 60, 0, 0, 3 * STALL_CYCLES, 1'b0, 1'b0);
    checks++; if (obs_underrun_cyc >= 0) begin errors++; $display("FAIL byte0_no_underrun: got underrun at %0d expected none", obs_underrun_cyc); end
    checks++; if (obs_vec !== model_bits() || obs_nbits != NBITS) begin errors++;
      $display("FAIL byte0_bits: got %h (%0d bits) expected %h", obs_vec, obs_nbits, model_bits()); end
  endtask

  task automatic test_underrun();
    rand_frame();
`ifdef WS_UNDERRUN_EN
    run_frame(1'b1, 100, 0, 4, 100000, 1'b0, 1'b0);
    checks++; if (obs_nbits != 32) begin errors++; $display("FAIL ur_nbits: got %0d expected 32", obs_nbits); end
    checks++; if (obs_underrun_cyc != obs_last_hs + STALL_CYCLES + 1) begin errors++;
      $display("FAIL ur_time: got %0d expected %0d", obs_underrun_cyc - obs_last_hs, STALL_CYCLES + 1); end
    checks++; if (obs_done_cyc != obs_underrun_cyc + LATCH_CYCLES || obs_done_pulses != 1) begin errors++;
      $display("FAIL ur_done: got %0d pulses=%0d expected %0d pulses=1", obs_done_cyc - obs_underrun_cyc, obs_done_pulses, LATCH_CYCLES); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
    rand_frame();
    run_frame(1'b1, 100, 0, -1, 0, 1'b0, 1'b0);
    checks++; if (obs_underrun_at_start !== 1'b0 || obs_underrun_cyc >= 0) begin errors++;
      $display("FAIL ur_clear: got %b expected 0", obs_underrun_at_start); end
    checks++; if (obs_vec !== model_bits()) begin errors++; $display("FAIL ur_next_bits: got %h expected %h", obs_vec, model_bits()); end
`else
    run_frame(1'b1, 100, 0, 4, 5 * STALL_CYCLES, 1'b0, 1'b0);
    checks++; if (obs_underrun_cyc >= 0) begin errors++; $display("FAIL nour_flag: got underrun at %0d expected none", obs_underrun_cyc); end
    checks++; if (obs_busy_gap != 0) begin errors++; $display("FAIL nour_busy: got %0d idle cycles expected 0", obs_busy_gap); end
    checks++; if (obs_vec !== model_bits() || obs_nbits != NBITS) begin errors++;
      $display("FAIL nour_bits: got %h (%0d bits) expected %h", obs_vec, obs_nbits, model_bits()); end
`endif
  endtask

  task automatic test_start_ignored();
    rand_frame();
    run_frame(1'b1, 60, 0, -1, 0, 1'b1, 1'b0);
    checks++; if (obs_vec !== model_bits() || obs_nbits != NBITS) begin errors++;
      $display("FAIL ign_bits: got %h (%0d bits) expected %h", obs_vec, obs_nbits, model_bits()); end
    checks++; if (obs_done_pulses != 1 || obs_busy_gap != 0) begin errors++;
      $display("FAIL ign_flow: got pulses=%0d gap=%0d expected 1 0", obs_done_pulses, obs_busy_gap); end
    checks++; if (obs_done_cyc != obs_last_hs + LATCH_CYCLES + 1) begin errors++;
      $display("FAIL ign_done_time: got %0d expected %0d", obs_done_cyc - obs_last_hs, LATCH_CYCLES + 1); end
  endtask

  task automatic test_back_to_back();
    rand_frame();
    run_frame(1'b1, 80, 0, -1, 0, 1'b0, 1'b1);
    checks++; if (obs_chain_ok !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b expected 1", obs_chain_ok); end
    rand_frame();
    run_frame(1'b0, 80, 0, -1, 0, 1'b0, 1'b0);
    checks++; if (obs_vec !== model_bits() || obs_nbits != NBITS) begin errors++;
      $display("FAIL b2b_bits: got %h (%0d bits) expected %h", obs_vec, obs_nbits, model_bits()); end
    checks++; if (obs_done_cyc < 0) begin errors++; $display("FAIL b2b_done: got none expected pulse"); end
  endtask

  initial begin
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    bus.enc_ready  = 1'b0;
    bus.enc_idle   = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_latch_hold();
    test_first_byte_wait();
    test_underrun();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
